// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  localparam int          DRAIN_CYCLES_DEF = 3;
  // Wide enough for MD_LAT-2 (MD_LAT <= 15) and DRAIN_CYCLES-1 (DRAIN_CYCLES <= 16)
  localparam int          CNT_W            = 4;
  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam logic [15:0] STALL_MAX        = 16'hFFFF;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational load-use comparator between the ID sources and the EX destination
module hazard_cmp #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          use_ra1,
  input  logic          use_ra2,
  input  logic [AW-1:0] dest,
  input  logic          mem_read,
  output logic          hazard
);

  // Register 0 is not special-cased: a load to r0 still stalls a reader of r0
  assign hazard = mem_read & ((use_ra1 & (ra1 == dest)) | (use_ra2 & (ra2 == dest)));

endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - stall/flush/bubble sequencer for the 5-stage pipeline
// Handles load-use stalls, branch redirects, multi-cycle EX waits and halt drain/resume.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT       = 4,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1_id,
  input  logic [AW-1:0] ra2_id,
  input  logic          use_ra1_id,
  input  logic          use_ra2_id,
  input  logic [AW-1:0] dest_ex,
  input  logic          memRead_ex,
  input  logic [1:0]    pc_source_id,
  input  logic          halt_id,
  input  logic          md_start_id,
  input  logic          resume,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          md_busy,
  output logic          halted,
  output logic [15:0]   stall_cnt
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             redirect;

  hazard_cmp #(.AW(AW)) u_hazard_cmp (
    .ra1      (ra1_id),
    .ra2      (ra2_id),
    .use_ra1  (use_ra1_id),
    .use_ra2  (use_ra2_id),
    .dest     (dest_ex),
    .mem_read (memRead_ex),
    .hazard   (load_use)
  );

  assign redirect = (pc_source_id != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (load_use) begin
          state_d = RUN;
        end else if (redirect) begin
          state_d = RUN;
        end else if (md_start_id) begin
          if (MD_LAT > 1) begin
            state_d = MD_WAIT;
            cnt_d   = CNT_W'(MD_LAT - 2);
          end
        end else if (halt_id) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      MD_WAIT: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    halted      = 1'b0;
    // While reset is held the front end is frozen and NOPs are injected
    if (!reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (redirect) begin
            ifid_flush = 1'b1;
          end else if (md_start_id) begin
            pc_write = 1'b1;
          end else if (halt_id) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          idex_bubble = 1'b1;
          md_busy     = 1'b1;
        end
        DRAIN: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        HALTED: begin
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state_q != HALTED) && !pc_write && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - directed self-checking bench for pipe_sequencer
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ra1_id, ra2_id, dest_ex;
  logic        use_ra1_id, use_ra2_id, memRead_ex;
  logic [1:0]  pc_source_id;
  logic        halt_id, md_start_id, resume;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, halted;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_sequencer #(.MD_LAT(4), .DRAIN_CYCLES(3), .AW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ra1_id       (ra1_id),
    .ra2_id       (ra2_id),
    .use_ra1_id   (use_ra1_id),
    .use_ra2_id   (use_ra2_id),
    .dest_ex      (dest_ex),
    .memRead_ex   (memRead_ex),
    .pc_source_id (pc_source_id),
    .halt_id      (halt_id),
    .md_start_id  (md_start_id),
    .resume       (resume),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .md_busy      (md_busy),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ra1_id = 4'd0; ra2_id = 4'd0; dest_ex = 4'd0;
    use_ra1_id = 1'b0; use_ra2_id = 1'b0; memRead_ex = 1'b0;
    pc_source_id = 2'd0; halt_id = 1'b0; md_start_id = 1'b0; resume = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ifid_write", ifid_write, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_bubble", idex_bubble, 1);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    reset = 1'b1; #1;
    chk("run_pc_write", pc_write, 1);
    chk("run_ifid_write", ifid_write, 1);
    chk("run_ifid_flush", ifid_flush, 0);
    chk("run_idex_bubble", idex_bubble, 0);
    repeat (20) @(negedge clk);
    chk("idle_stall_cnt", stall_cnt, 0);
    chk("idle_pc_write", pc_write, 1);

    // load-use on ra1
    memRead_ex = 1'b1; dest_ex = 4'd3; ra1_id = 4'd3; use_ra1_id = 1'b1; #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_bubble", idex_bubble, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    @(negedge clk);
    clear_inputs(); #1;
    chk("lu_after_pc_write", pc_write, 1);
    chk("lu_after_bubble", idex_bubble, 0);
    chk("lu_stall_cnt", stall_cnt, 1);

    // match with use bit off: no stall
    memRead_ex = 1'b1; dest_ex = 4'd5; ra1_id = 4'd5; use_ra1_id = 1'b0; #1;
    chk("lu_unused_pc_write", pc_write, 1);
    // load-use on ra2 with register 0
    ra1_id = 4'd7; dest_ex = 4'd0; ra2_id = 4'd0; use_ra2_id = 1'b1; #1;
    chk("lu_r0_pc_write", pc_write, 0);
    chk("lu_r0_bubble", idex_bubble, 1);
    @(negedge clk);
    clear_inputs(); #1;
    chk("lu_r0_stall_cnt", stall_cnt, 2);

    // load-use wins over redirect, redirect acts once the hazard is gone
    memRead_ex = 1'b1; dest_ex = 4'd3; ra1_id = 4'd3; use_ra1_id = 1'b1; pc_source_id = 2'd2; #1;
    chk("lu_br_flush", ifid_flush, 0);
    chk("lu_br_pc_write", pc_write, 0);
    @(negedge clk);
    memRead_ex = 1'b0; #1;
    chk("br_flush", ifid_flush, 1);
    chk("br_pc_write", pc_write, 1);
    chk("br_bubble", idex_bubble, 0);
    @(negedge clk);
    clear_inputs(); #1;
    chk("br_after_flush", ifid_flush, 0);
    chk("br_stall_cnt", stall_cnt, 3);

    // multi-cycle op: 3 frozen cycles
    md_start_id = 1'b1; #1;
    chk("md_issue_pc_write", pc_write, 1);
    chk("md_issue_busy", md_busy, 0);
    @(negedge clk);
    md_start_id = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("md_wait_busy", md_busy, 1);
      chk("md_wait_pc_write", pc_write, 0);
      chk("md_wait_bubble", idex_bubble, 1);
      @(negedge clk);
    end
    chk("md_done_busy", md_busy, 0);
    chk("md_done_pc_write", pc_write, 1);
    chk("md_stall_cnt", stall_cnt, 6);

    // halt drain, resume ignored while draining
    halt_id = 1'b1; #1;
    chk("halt_pc_write", pc_write, 0);
    chk("halt_flush", ifid_flush, 1);
    @(negedge clk);
    halt_id = 1'b0; #1;
    chk("drain1_halted", halted, 0);
    chk("drain1_pc_write", pc_write, 0);
    chk("drain1_flush", ifid_flush, 1);
    @(negedge clk);
    resume = 1'b1;
    chk("drain2_halted", halted, 0);
    @(negedge clk);
    resume = 1'b0;
    chk("drain3_halted", halted, 0);
    @(negedge clk);
    chk("halted_edge4", halted, 1);
    chk("halted_pc_write", pc_write, 0);
    repeat (3) @(negedge clk);
    chk("halted_hold", halted, 1);
    chk("halted_stall_cnt", stall_cnt, 10);
    resume = 1'b1; #1;
    chk("resume_same_halted", halted, 1);
    @(negedge clk);
    resume = 1'b0; #1;
    chk("resume_halted", halted, 0);
    chk("resume_pc_write", pc_write, 1);
    chk("resume_stall_cnt", stall_cnt, 10);

    // async reset in the first MD_WAIT cycle (counter=2)
    md_start_id = 1'b1;
    @(negedge clk);
    md_start_id = 1'b0; #1;
    chk("mdr_busy_pre", md_busy, 1);
    #2 reset = 1'b0; #1;
    chk("mdr_busy_rst", md_busy, 0);
    chk("mdr_stall_rst", stall_cnt, 0);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("mdr_busy_rel", md_busy, 0);
    chk("mdr_pc_write_rel", pc_write, 1);
    @(negedge clk);
    chk("mdr_busy_next", md_busy, 0);
    chk("mdr_pc_write_next", pc_write, 1);

    // held load-use saturates the stall counter
    memRead_ex = 1'b1; dest_ex = 4'd9; ra2_id = 4'd9; use_ra2_id = 1'b1;
    repeat (65540) @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat_pc_write", pc_write, 0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
